// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU:
//   - 4-bit opcode encodings (OP_ADD .. OP_CMP)
//   - bit positions of the {N,Z,V,C} flag vector
//   - FSM state encoding of the top-level sequencer
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_LAND = 4'd2;
    localparam logic [3:0] OP_LOR  = 4'd3;
    localparam logic [3:0] OP_BAND = 4'd4;
    localparam logic [3:0] OP_BOR  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_INC  = 4'd7;
    localparam logic [3:0] OP_DEC  = 4'd8;
    localparam logic [3:0] OP_ADC  = 4'd9;
    localparam logic [3:0] OP_SBC  = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;
    localparam logic [3:0] OP_SHR  = 4'd12;
    localparam logic [3:0] OP_ROL  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_CMP  = 4'd15;

    // Flag vector layout: nzvc = {N, Z, V, C}
    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_V = 1;
    localparam int F_C = 0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_BUSY = 2'd1,
        S_DONE     = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// ----------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add unsigned multiplier, one partial product per clock.
// A start pulse loads the operands; the next WIDTH clock edges each retire one
// multiplier bit. 'done' is high during the cycle whose closing edge performs
// the final iteration, and 'product' always shows the accumulator value that
// edge will produce, so the consumer can capture the full product on that
// same edge without an extra cycle of latency.
//
// Ports:
//   clk      in   1        system clock, rising edge
//   rst_n    in   1        asynchronous active-low reset (aborts a multiply)
//   start    in   1        load a/b and begin a new multiply
//   a        in   WIDTH    multiplicand
//   b        in   WIDTH    multiplier
//   done     out  1        final iteration happens at the end of this cycle
//   product  out  2*WIDTH  accumulator after the current iteration
// ----------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic                 busy;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mcand;
    // Upper half accumulates partial sums; lower half starts as the
    // multiplier and is shifted out one bit per iteration.
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_next;

    // NOTE: every variable assigned in an always_comb gets a default value
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            sum = sum + {1'b0, mcand};
        end
        acc_next = {sum, acc[WIDTH-1:1]};
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH);
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
        end else if (busy) begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done    = busy && (cnt == CW'(1));
    assign product = acc_next;

endmodule

// File: rtl/alu_multicycle.sv
// ----------------------------------------------------------------------------
// alu_multicycle
// Handshaked ALU with registered result and {N,Z,V,C} flags. Single-cycle ops
// are evaluated combinationally from the accepted inputs and registered on the
// acceptance edge; MUL is handed to an iterative multiplier and takes
// WIDTH+1 cycles. Only one op is in flight; a finished result is held until
// the consumer takes it, and a new op may be accepted on that same edge.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      op/a/b valid
//   in_ready   out  1      op accepted when in_valid & in_ready
//   op         in   4      opcode (alu_pkg encoding)
//   a, b       in   WIDTH  operands
//   out_valid  out  1      result/result_hi/nzvc valid
//   out_ready  in   1      result taken when out_valid & out_ready
//   result     out  WIDTH  result (MUL: low half)
//   result_hi  out  WIDTH  MUL high half, 0 for other ops
//   nzvc       out  4      registered flags; C is the carry-in of ADC/SBC/ROL
// ----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic [3:0]         nzvc
);

    import alu_pkg::*;

    state_t               state;
    logic                 accept;
    logic                 start_mul;
    logic                 c_flag;

    // Single-cycle datapath
    logic [WIDTH-1:0]     opb;
    logic                 cin;
    logic                 is_sub;
    logic [WIDTH:0]       arith;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_v;
    logic                 alu_c;
    logic [3:0]           alu_flags;

    // Multiplier interface
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH-1:0]     mul_hi;
    logic [3:0]           mul_flags;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && MUL_EN && (op == OP_MUL);
    // The flag register already holds the flags of any op being retired on
    // this edge, which is exactly the carry an accepted ADC/SBC/ROL must see.
    assign c_flag    = nzvc[F_C];

    // Operand conditioning for the shared WIDTH+1 bit adder/subtractor
    always_comb begin
        opb    = b;
        cin    = 1'b0;
        is_sub = 1'b0;
        case (op)
            OP_SUB, OP_CMP: is_sub = 1'b1;
            OP_INC:         opb    = WIDTH'(1);
            OP_DEC: begin
                opb    = WIDTH'(1);
                is_sub = 1'b1;
            end
            OP_ADC:         cin    = c_flag;
            OP_SBC: begin
                cin    = c_flag;
                is_sub = 1'b1;
            end
            default: ;
        endcase

        if (is_sub) begin
            arith = {1'b0, a} - {1'b0, opb} - {{WIDTH{1'b0}}, cin};
        end else begin
            arith = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        end
    end

    // Result selection and flag generation
    always_comb begin
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
        if (is_sub) begin
            alu_v = (a[WIDTH-1] ^ arith[WIDTH-1]) & (a[WIDTH-1] ^ opb[WIDTH-1]);
        end else begin
            alu_v = (a[WIDTH-1] ^ arith[WIDTH-1]) & ~(a[WIDTH-1] ^ opb[WIDTH-1]);
        end

        case (op)
            OP_LAND: begin
                alu_res = {{(WIDTH-1){1'b0}}, (|a) & (|b)};
                alu_v   = 1'b0;
                alu_c   = 1'b0;
            end
            OP_LOR: begin
                alu_res = {{(WIDTH-1){1'b0}}, (|a) | (|b)};
                alu_v   = 1'b0;
                alu_c   = 1'b0;
            end
            OP_BAND: begin
                alu_res = a & b;
                alu_v   = 1'b0;
                alu_c   = 1'b0;
            end
            OP_BOR: begin
                alu_res = a | b;
                alu_v   = 1'b0;
                alu_c   = 1'b0;
            end
            OP_XOR: begin
                alu_res = a ^ b;
                alu_v   = 1'b0;
                alu_c   = 1'b0;
            end
            OP_SHL: begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_v   = 1'b0;
                alu_c   = a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a[WIDTH-1:1]};
                alu_v   = 1'b0;
                alu_c   = a[0];
            end
            OP_ROL: begin
                alu_res = {a[WIDTH-2:0], c_flag};
                alu_v   = 1'b0;
                alu_c   = a[WIDTH-1];
            end
            OP_MUL: begin
                // Only reached when the multiplier is not built: NOP result
                alu_res = '0;
                alu_v   = 1'b0;
                alu_c   = 1'b0;
            end
            default: ;
        endcase

        alu_flags        = '0;
        alu_flags[F_N]   = alu_res[WIDTH-1];
        alu_flags[F_Z]   = (alu_res == '0);
        alu_flags[F_V]   = alu_v;
        alu_flags[F_C]   = alu_c;
        if (op == OP_MUL) begin
            alu_flags = nzvc;
        end
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (start_mul),
                .a       (a),
                .b       (b),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign mul_hi = mul_product[2*WIDTH-1:WIDTH];

    always_comb begin
        mul_flags      = '0;
        mul_flags[F_N] = mul_hi[WIDTH-1];
        mul_flags[F_Z] = (mul_product == '0);
        mul_flags[F_V] = (mul_hi != '0);
        mul_flags[F_C] = (mul_hi != '0);
    end

    // Sequencer and output registers. out_valid is kept equal to
    // (state == S_DONE) so the consumer sees a clean registered strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            nzvc      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (start_mul) begin
                            state     <= S_MUL_BUSY;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            nzvc      <= alu_flags;
                            // CMP only updates flags
                            if (op != OP_CMP) begin
                                result    <= alu_res;
                                result_hi <= '0;
                            end
                        end
                    end else if ((state == S_DONE) && out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_MUL_BUSY: begin
                    if (mul_done) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= mul_product[WIDTH-1:0];
                        result_hi <= mul_hi;
                        nzvc      <= mul_flags;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_alu_multicycle
// Directed scenarios for the documented corner cases plus a randomized
// handshake stream compared against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_alu_multicycle;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result;
    logic [7:0]  result_hi;
    logic [3:0]  nzvc;

    int checks = 0;
    int errors = 0;

    // Reference model state: value of the DUT registers after the last op
    logic [7:0]  m_res = 8'h00;
    logic [7:0]  m_hi  = 8'h00;
    logic [3:0]  m_f   = 4'b0000;

    alu_multicycle #(
        .WIDTH  (8),
        .MUL_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .nzvc      (nzvc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic on unsigned/signed views.
    task automatic model_exec(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                              output logic [7:0] r, output logic [7:0] h, output logic [3:0] f);
        int ux, uy, sx, sy, cin, full, sfull, p;
        logic [7:0] fr;
        logic v, c;
        ux = x; uy = y; sx = $signed(x); sy = $signed(y); cin = m_f[0];
        h = 8'h00; v = 1'b0; c = 1'b0; fr = 8'h00;
        p = 0;
        if (o == 4'd7 || o == 4'd8) begin uy = 1; sy = 1; end
        if (!(o == 4'd9 || o == 4'd10)) cin = 0;
        case (o)
            4'd0, 4'd7, 4'd9: begin
                full = ux + uy + cin; sfull = sx + sy + cin;
                fr = 8'(full); c = (full > 255); v = (sfull > 127) || (sfull < -128);
            end
            4'd1, 4'd8, 4'd10, 4'd15: begin
                full = ux - uy - cin; sfull = sx - sy - cin;
                fr = 8'(full); c = (full < 0); v = (sfull > 127) || (sfull < -128);
            end
            4'd2:  fr = ((ux != 0) && (uy != 0)) ? 8'd1 : 8'd0;
            4'd3:  fr = ((ux != 0) || (uy != 0)) ? 8'd1 : 8'd0;
            4'd4:  fr = x & y;
            4'd5:  fr = x | y;
            4'd6:  fr = x ^ y;
            4'd11: begin fr = 8'((ux * 2) % 256); c = (ux >= 128); end
            4'd12: begin fr = 8'(ux / 2); c = (ux % 2 == 1); end
            4'd13: begin fr = 8'((ux * 2) % 256 + m_f[0]); c = (ux >= 128); end
            default: begin
                p  = ux * uy;
                fr = 8'(p % 256);
                h  = 8'(p / 256);
            end
        endcase
        if (o == 4'd14) begin
            f = {h >= 8'd128, p == 0, h != 8'h00, h != 8'h00};
            r = fr;
        end else begin
            f = {fr >= 8'd128, fr == 8'h00, v, c};
            r = fr;
            if (o == 4'd15) begin
                r = m_res;
                h = m_hi;
            end
        end
        m_res = r; m_hi = h; m_f = f;
    endtask

    // Issues one op from idle, waits (bounded) for the result, then retires it.
    // lat = cycles from acceptance edge to out_valid, or -1 on timeout.
    task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] r, output logic [7:0] h, output logic [3:0] f,
                          output int lat, output bit ready_while_busy);
        logic [7:0] er, eh;
        logic [3:0] ef;
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        model_exec(o, x, y, er, eh, ef);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        op = 4'($urandom);
        lat = -1;
        ready_while_busy = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            if (in_ready) ready_while_busy = 1'b1;
            @(negedge clk);
        end
        r = result; h = result_hi; f = nzvc;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = 8'h00; b = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, result, result_hi, nzvc} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b vld=%b res=%h hi=%h nzvc=%b expected rdy=1 vld=0 res=00 hi=00 nzvc=0000",
                     in_ready, out_valid, result, result_hi, nzvc);
        end
        rst_n = 1'b1;
        m_res = 8'h00; m_hi = 8'h00; m_f = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_add_adc();
        logic [7:0] r, h; logic [3:0] f; int lat; bit rb;
        run_op(4'd0, 8'h7F, 8'h01, r, h, f, lat, rb);
        checks++;
        if ({r, h, f} !== {8'h80, 8'h00, 4'b1010} || lat !== 1) begin
            errors++;
            $display("FAIL add_7f_01 got res=%h hi=%h nzvc=%b lat=%0d expected res=80 hi=00 nzvc=1010 lat=1", r, h, f, lat);
        end
        run_op(4'd9, 8'hFF, 8'h00, r, h, f, lat, rb);
        checks++;
        if ({r, h, f} !== {8'hFF, 8'h00, 4'b1000} || lat !== 1) begin
            errors++;
            $display("FAIL adc_ff_00 got res=%h hi=%h nzvc=%b lat=%0d expected res=ff hi=00 nzvc=1000 lat=1", r, h, f, lat);
        end
        run_op(4'd0, 8'hFF, 8'h01, r, h, f, lat, rb);
        checks++;
        if ({r, f} !== {8'h00, 4'b0101}) begin
            errors++;
            $display("FAIL add_wrap got res=%h nzvc=%b expected res=00 nzvc=0101", r, f);
        end
    endtask

    task automatic test_sub_sbc_cmp();
        logic [7:0] r, h; logic [3:0] f; int lat; bit rb;
        run_op(4'd1, 8'h00, 8'h01, r, h, f, lat, rb);
        checks++;
        if ({r, f} !== {8'hFF, 4'b1001}) begin
            errors++;
            $display("FAIL sub_00_01 got res=%h nzvc=%b expected res=ff nzvc=1001", r, f);
        end
        run_op(4'd10, 8'h05, 8'h02, r, h, f, lat, rb);
        checks++;
        if ({r, f} !== {8'h02, 4'b0000}) begin
            errors++;
            $display("FAIL sbc_05_02 got res=%h nzvc=%b expected res=02 nzvc=0000", r, f);
        end
        run_op(4'd15, 8'h10, 8'h10, r, h, f, lat, rb);
        checks++;
        if ({r, h, f} !== {8'h02, 8'h00, 4'b0100}) begin
            errors++;
            $display("FAIL cmp_10_10 got res=%h hi=%h nzvc=%b expected res=02 hi=00 nzvc=0100", r, h, f);
        end
        run_op(4'd8, 8'h00, 8'h55, r, h, f, lat, rb);
        checks++;
        if ({r, f} !== {8'hFF, 4'b1001}) begin
            errors++;
            $display("FAIL dec_wrap got res=%h nzvc=%b expected res=ff nzvc=1001", r, f);
        end
    endtask

    task automatic test_mul();
        logic [7:0] r, h; logic [3:0] f; int lat; bit rb;
        run_op(4'd14, 8'hFF, 8'hFF, r, h, f, lat, rb);
        checks++;
        if ({r, h, f} !== {8'h01, 8'hFE, 4'b1011}) begin
            errors++;
            $display("FAIL mul_ff_ff got res=%h hi=%h nzvc=%b expected res=01 hi=fe nzvc=1011", r, h, f);
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL mul_latency got %0d expected 9", lat);
        end
        checks++;
        if (rb !== 1'b0) begin
            errors++;
            $display("FAIL mul_in_ready_busy got in_ready=1 during busy expected 0");
        end
        // A following non-MUL op must clear result_hi
        run_op(4'd6, 8'hA5, 8'h0F, r, h, f, lat, rb);
        checks++;
        if ({r, h, f} !== {8'hAA, 8'h00, 4'b1000}) begin
            errors++;
            $display("FAIL xor_after_mul got res=%h hi=%h nzvc=%b expected res=aa hi=00 nzvc=1000", r, h, f);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] er, eh; logic [3:0] ef;
        bit ok;
        op = 4'd0; a = 8'h03; b = 8'h04; in_valid = 1'b1; out_ready = 1'b0;
        model_exec(4'd0, 8'h03, 8'h04, er, eh, ef);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_first_result got out_valid=0 after 20 cycles expected 1");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, result, result_hi, nzvc} !== {1'b1, 1'b0, 8'h07, 8'h00, 4'b0000}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b res=%h hi=%h nzvc=%b expected vld=1 rdy=0 res=07 hi=00 nzvc=0000",
                         i, out_valid, in_ready, result, result_hi, nzvc);
            end
            @(negedge clk);
        end
        out_ready = 1'b1; op = 4'd0; a = 8'h10; b = 8'h20; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_same_cycle_ready got %b expected 1", in_ready);
        end
        model_exec(4'd0, 8'h10, 8'h20, er, eh, ef);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if ({out_valid, result, nzvc} !== {1'b1, 8'h30, 4'b0000}) begin
            errors++;
            $display("FAIL bp_next_result got vld=%b res=%h nzvc=%b expected vld=1 res=30 nzvc=0000", out_valid, result, nzvc);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_rol_shr();
        logic [7:0] r, h; logic [3:0] f; int lat; bit rb;
        run_op(4'd1, 8'h00, 8'h01, r, h, f, lat, rb);   // sets C=1
        run_op(4'd13, 8'h81, 8'h00, r, h, f, lat, rb);
        checks++;
        if ({r, f} !== {8'h03, 4'b0001}) begin
            errors++;
            $display("FAIL rol_81_c1 got res=%h nzvc=%b expected res=03 nzvc=0001", r, f);
        end
        run_op(4'd12, 8'h01, 8'h00, r, h, f, lat, rb);
        checks++;
        if ({r, f} !== {8'h00, 4'b0101}) begin
            errors++;
            $display("FAIL shr_01 got res=%h nzvc=%b expected res=00 nzvc=0101", r, f);
        end
    endtask

    function automatic logic [7:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h7F;
            3: return 8'h80;
            4: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic test_back_to_back_random(input int n);
        logic [19:0] exp_q[$];
        logic [19:0] exp_v;
        logic [7:0]  er, eh;
        logic [3:0]  ef;
        int issued = 0;
        int retired = 0;
        int cyc = 0;
        bit accepted;
        in_valid = 1'b0; out_ready = 1'b0;
        while (retired < n && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && issued < n && $urandom_range(0, 3) != 0) begin
                op = 4'($urandom_range(0, 15));
                a = pick_operand();
                b = pick_operand();
                in_valid = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_unexpected_result got res=%h hi=%h nzvc=%b expected no result", result, result_hi, nzvc);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({result, result_hi, nzvc} !== exp_v) begin
                        errors++;
                        $display("FAIL rnd_result #%0d got res=%h hi=%h nzvc=%b expected res=%h hi=%h nzvc=%b",
                                 retired, result, result_hi, nzvc, exp_v[19:12], exp_v[11:4], exp_v[3:0]);
                    end
                end
                retired++;
            end
            accepted = 1'b0;
            if (in_valid && in_ready) begin
                model_exec(op, a, b, er, eh, ef);
                exp_q.push_back({er, eh, ef});
                issued++;
                accepted = 1'b1;
            end
            @(negedge clk);
            if (accepted) in_valid = 1'b0;
            cyc++;
        end
        checks++;
        if (retired < n) begin
            errors++;
            $display("FAIL rnd_timeout got %0d results expected %0d", retired, n);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        int stray = 0;
        op = 4'd14; a = 8'hC3; b = 8'h5A; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, nzvc, result, result_hi} !== {1'b0, 1'b1, 4'b0000, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_mul got vld=%b rdy=%b nzvc=%b res=%h hi=%h expected vld=0 rdy=1 nzvc=0000 res=00 hi=00",
                     out_valid, in_ready, nzvc, result, result_hi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_stray_valid got %0d cycles with out_valid expected 0", stray);
        end
        out_ready = 1'b0;
        m_res = 8'h00; m_hi = 8'h00; m_f = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_add_adc();
        test_sub_sbc_cmp();
        test_mul();
        test_backpressure();
        test_rol_shr();
        test_back_to_back_random(400);
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
